mem_model_pipelined: RTL and testbench
======================================

# mem_model_pipelined

Parametrised, pipelined behavioural memory model for SimpleARM testbenches. It accepts requests through a valid/ready handshake and keeps up to MAX_OUTSTANDING requests in flight. It returns in-order responses after independently configurable read and write latencies, and flags out-of-range or misaligned accesses. It sits between the core's bus port and the bench, with backdoor tasks for preload, dump and error injection.

## Interface
- DATA_W, 32: data width in bits; power of two, at least 8.
- ADDR_W, 32: address width.
- MEM_BYTES, 8192: byte capacity; multiple of DATA_W/8.
- BASE_ADDR, 0: byte address of mem[0].
- RD_LAT, 2: read latency in cycles; at least 1.
- WR_LAT, 1: write latency in cycles; at least 1.
- MAX_OUTSTANDING, 4: response queue depth; at least 1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request can be accepted.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  access error.

## Operation
- A request is accepted on a rising edge with req_valid && req_ready.
- req_ready = (occupancy < MAX_OUTSTANDING). It is registered state only, with no combinational path from rsp_ready.
- Access check at acceptance: off = req_addr − BASE_ADDR.
  - Error if req_addr < BASE_ADDR, off + DATA_W/8 > MEM_BYTES, or off is not a multiple of DATA_W/8.
- Writes commit to the array on the acceptance edge, for enabled bytes only.
  - Little-endian: byte i goes to mem[off+i].
  - Errored writes do not modify memory.
  - be == 0 is a legal no-op write with err = 0.
- Reads snapshot data on the acceptance edge and include writes accepted on earlier edges, so read-after-write is coherent.
  - Errored reads return rdata = 0.
- Each accepted request pushes a queue entry {write, err, rdata, cnt}, with cnt = RD_LAT − 1 or WR_LAT − 1.
- Every cycle, every entry with cnt ≠ 0 decrements, including entries not at the head.
- rsp_valid = queue not empty && head.cnt == 0. The head pops on rsp_valid && rsp_ready.
- Responses are strictly in order: a short-latency write behind a read waits for the read's response.
- A simultaneous push and pop leaves occupancy unchanged. A full queue plus a pop in the same cycle does not accept a new request that cycle.
- Backdoor tasks (non-synthesisable):
  - load_hex(file)
  - dump(file, start, end): word format "%08h: %0*h".
  - peek(addr) returns a byte.
  - poke(addr, byte).
  - fill_pattern(p): mem[i] = p ^ i[7:0].
  - compare(file, out match).
  - Backdoor addresses are array indices, not bus addresses.

## Timing
- Reset values: req_ready = 1, rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, rsp_err = 0, occupancy = 0, all entries cleared.
- The memory array is not cleared by rst.
- Request accepted at edge N: rsp_valid is high in the cycle after edge N + LAT − 1, i.e. LAT cycles after acceptance, provided the entry is at the head.
- Back-to-back accepts of the same type give one response per cycle.
- While rsp_valid && !rsp_ready, rsp_write, rsp_rdata and rsp_err hold stable.
- Reset mid-operation: all outstanding responses are discarded in the next cycle. Writes already accepted stay committed.
- The queue pointers wrap modulo MAX_OUTSTANDING. Occupancy has clog2(MAX_OUTSTANDING+1) bits, so full and empty are distinguished.
- The cnt field is clog2(max(RD_LAT, WR_LAT)) + 1 bits wide.

## Structure
- Package mem_model_pkg holds the rsp_entry_t struct (write, err, rdata, cnt), a latency-width localparam helper, and an is_access_err function.
- Sub-module mem_rsp_queue: a circular FIFO with per-entry countdown, parametrised by depth, DATA_W and cnt width. Push/pop/full/empty and head fields are exported.
- The top level contains the byte array, the access check, the write commit and the read snapshot.

## Test plan
1. Write 0xDEADBEEF to 0x100 with be = 4'hF, then read 0x100 on the next cycle. Required: the write response arrives 1 cycle after acceptance with err = 0; the read response arrives 2 cycles after its acceptance with rdata = 0xDEADBEEF.
2. poke 0x200..0x203 so the word reads 0x11223344, then write wdata 0xAABBCCDD with be = 4'b0101 and read 0x200. Required: rdata = 0x11BB33DD.
3. Five back-to-back reads with rsp_ready = 0. Required: req_ready drops after the 4th accept. Then raise rsp_ready. Required: four responses arrive in order on consecutive cycles, and the 5th request is accepted the cycle after the first pop.
4. Required: read 0x1FFC gives err = 0; read 0x2000 gives err = 1 with rdata = 0; read 0x102 gives err = 1. After a write to 0x2000, peek of the whole array shows no change.
5. Read 0x100 followed immediately by a write to 0x104. Required: the write response does not appear before the read response, and rsp_write is 0 then 1.
6. With 3 requests outstanding, assert rst for 1 cycle. Required: next cycle rsp_valid = 0 and req_ready = 1; a subsequent read of a previously written address returns the committed data.

Source files
------------

// File: rtl/mem_model_pkg.sv
// ---------------------------------------------------------------------------
// mem_model_pkg
// Shared helpers for the pipelined memory model:
//   cnt_width()     - width of the per-entry latency countdown,
//                     clog2(max(RD_LAT, WR_LAT)) + 1.
//   is_access_err() - address check applied when a request is accepted:
//                     below base, past the end of the array, or not aligned
//                     to the word size.
// ---------------------------------------------------------------------------
package mem_model_pkg;

  function automatic int cnt_width(input int rd_lat, input int wr_lat);
    int max_lat;
    max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return $clog2(max_lat) + 1;
  endfunction

  // All arguments are widened to 64 bits so that off + word_bytes cannot
  // wrap for any ADDR_W up to 63.
  function automatic logic is_access_err(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] mem_bytes,
                                         input logic [63:0] word_bytes);
    logic [63:0] off;
    if (addr < base) return 1'b1;
    off = addr - base;
    return ((off + word_bytes) > mem_bytes) ||
           ((off & (word_bytes - 64'd1)) != 64'd0);
  endfunction

endpackage

// File: rtl/mem_rsp_queue.sv
// ---------------------------------------------------------------------------
// mem_rsp_queue
// Circular response FIFO in which every stored entry carries its own latency
// countdown. All non-zero counters decrement every cycle, including entries
// behind the head, so a response whose latency already expired while waiting
// is presented the cycle it reaches the head.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears all entries)
//   push            store {push_write, push_err, push_rdata, push_cnt}
//   pop             retire the head entry
//   full, empty     occupancy == DEPTH / occupancy == 0
//   head_done       head countdown has reached zero
//   head_write/err/rdata  fields of the head entry
// ---------------------------------------------------------------------------
module mem_rsp_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_write,
  input  logic              push_err,
  input  logic [DATA_W-1:0] push_rdata,
  input  logic [CNT_W-1:0]  push_cnt,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic              head_done,
  output logic              head_write,
  output logic              head_err,
  output logic [DATA_W-1:0] head_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              write;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic [CNT_W-1:0]  cnt;
  } entry_t;

  entry_t           entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_done  = (entries[rd_ptr].cnt == '0);
  assign head_write = entries[rd_ptr].write;
  assign head_err   = entries[rd_ptr].err;
  assign head_rdata = entries[rd_ptr].rdata;

  // NOTE: non-blocking assignments make every counter, pointer and the
  // occupancy update from pre-edge values, so the order of the statements
  // below does not change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].cnt != '0) entries[i].cnt <= entries[i].cnt - CNT_W'(1);
      end
      // The slot being written is free, so its countdown is already zero and
      // the decrement above never competes with a fresh entry.
      if (do_push) begin
        entries[wr_ptr] <= '{write: push_write, err: push_err,
                             rdata: push_rdata, cnt: push_cnt};
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/mem_model_pipelined.sv
// ---------------------------------------------------------------------------
// mem_model_pipelined
// Pipelined byte-addressed memory model. Requests are accepted over a
// valid/ready handshake, writes commit and reads snapshot on the acceptance
// edge, and in-order responses are returned after RD_LAT / WR_LAT cycles
// through mem_rsp_queue. Out-of-range or misaligned accesses respond with
// rsp_err = 1 and never touch the array.
//
// Backdoor access for benches is by hierarchical reference to the byte array
// `mem`, indexed by array offset rather than bus address.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (req_ready = queue not full)
//   req_write                1 = write, 0 = read
//   req_addr                 byte address
//   req_wdata, req_be        write data and byte enables (bit i -> byte i)
//   rsp_valid / rsp_ready    response handshake
//   rsp_write                response belongs to a write
//   rsp_rdata                read data; 0 for writes and errors
//   rsp_err                  access error
// ---------------------------------------------------------------------------
module mem_model_pipelined
  import mem_model_pkg::*;
#(
  parameter int              DATA_W          = 32,
  parameter int              ADDR_W          = 32,
  parameter int              MEM_BYTES       = 8192,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int              RD_LAT          = 2,
  parameter int              WR_LAT          = 1,
  parameter int              MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam int CNT_W = cnt_width(RD_LAT, WR_LAT);

  // NOTE: the byte array has no reset; contents survive rst so that writes
  // accepted before a reset remain visible afterwards.
  logic [7:0]        mem [MEM_BYTES];

  logic              q_full;
  logic              q_empty;
  logic              q_head_done;
  logic              accept;
  logic              acc_err;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] push_rdata;
  logic [CNT_W-1:0]  push_cnt;

  // req_ready comes from registered occupancy only; a pop in the same cycle
  // does not open a slot until the next cycle.
  assign req_ready = !q_full;
  assign accept    = req_valid && req_ready && !rst;
  assign acc_err   = is_access_err(64'(req_addr), 64'(BASE_ADDR),
                                   64'(MEM_BYTES), 64'(BYTES));
  // Errored requests are steered to index 0 so the read path never indexes
  // outside the array; their data is discarded anyway.
  assign idx       = acc_err ? '0 : IDX_W'(req_addr - BASE_ADDR);

  // Little-endian snapshot of the word at idx; it reflects all writes
  // committed on earlier edges.
  // NOTE: rd_word gets a default before the loop so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BYTES; i++) rd_word[8*i +: 8] = mem[idx + IDX_W'(i)];
  end

  always_ff @(posedge clk) begin
    if (accept && req_write && !acc_err) begin
      for (int i = 0; i < BYTES; i++) begin
        if (req_be[i]) mem[idx + IDX_W'(i)] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign push_rdata = (req_write || acc_err) ? '0 : rd_word;
  assign push_cnt   = req_write ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);

  mem_rsp_queue #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_rsp_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_write (req_write),
    .push_err   (acc_err),
    .push_rdata (push_rdata),
    .push_cnt   (push_cnt),
    .pop        (rsp_valid && rsp_ready),
    .full       (q_full),
    .empty      (q_empty),
    .head_done  (q_head_done),
    .head_write (rsp_write),
    .head_err   (rsp_err),
    .head_rdata (rsp_rdata)
  );

  assign rsp_valid = !q_empty && q_head_done;

endmodule

// File: tb/tb_mem_model_pipelined.sv
// ---------------------------------------------------------------------------
// tb_mem_model_pipelined
// Scoreboard bench: the monitor captures each accepted request, derives the
// expected response from a flat byte-array model, and queues it together
// with the first cycle it may appear. Every cycle the monitor compares
// req_ready, rsp_valid and the head response fields against that queue.
// ---------------------------------------------------------------------------
module tb_mem_model_pipelined;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int MEMB  = 8192;
  localparam int RDL   = 2;
  localparam int WRL   = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  always #5 clk = ~clk;

  mem_model_pipelined #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_BYTES(MEMB), .BASE_ADDR('0),
    .RD_LAT(RDL), .WR_LAT(WRL), .MAX_OUTSTANDING(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rsp_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] model_mem [MEMB];

  typedef struct {
    bit          write;
    bit          err;
    logic [31:0] rdata;
    int          ready_cyc;
  } exp_t;

  exp_t sb[$];

  function automatic bit model_err(input logic [31:0] a);
    return (a % 4 != 0) || (longint'(a) + 4 > longint'(MEMB));
  endfunction

  // ---------------- monitor / scoreboard ----------------
  exp_t        cap;
  bit          exp_rv;
  logic [31:0] cap_a;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      exp_rv = (sb.size() > 0) && (cyc >= sb[0].ready_cyc);
      check("req_ready", 32'(req_ready), 32'(sb.size() < DEPTH));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (rsp_valid && sb.size() > 0) begin
        check("rsp_write", 32'(rsp_write), 32'(sb[0].write));
        check("rsp_err",   32'(rsp_err),   32'(sb[0].err));
        check("rsp_rdata", rsp_rdata,      sb[0].rdata);
        if (rsp_ready) void'(sb.pop_front());
      end
      if (req_valid && req_ready) begin
        cap_a         = req_addr;
        cap.write     = req_write;
        cap.err       = model_err(cap_a);
        cap.rdata     = '0;
        // Accepted on the coming edge (cyc+1); valid LAT-1 edges later.
        cap.ready_cyc = cyc + (req_write ? WRL : RDL);
        if (!cap.err) begin
          for (int b = 0; b < 4; b++) begin
            if (req_write) begin
              if (req_be[b]) model_mem[int'(cap_a) + b] = req_wdata[8*b +: 8];
            end else begin
              cap.rdata[8*b +: 8] = model_mem[int'(cap_a) + b];
            end
          end
        end
        sb.push_back(cap);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rsp_rand) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = req_ready && !rst;
      step();
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: addr %h not accepted within %0d cycles", a, n);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    step();
  endtask

  task automatic peek_all(input string name);
    int mism;
    mism = 0;
    for (int i = 0; i < MEMB; i++) begin
      if (dut.mem[i] !== model_mem[i]) mism++;
    end
    check(name, 32'(mism), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] word;
  logic [31:0] ra;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_write", 32'(rsp_write), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err",   32'(rsp_err), 32'd0);
    step();

    // Initialise the whole array with mem[i] = 0x5A ^ i[7:0].
    for (int w = 0; w < MEMB / 4; w++) begin
      for (int b = 0; b < 4; b++) word[8*b +: 8] = 8'h5A ^ 8'(4*w + b);
      issue(1'b1, 32'(4*w), word, 4'hF);
    end
    wait_idle();
    peek_all("peek_after_fill");

    // Write then read-after-write.
    issue(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    wait_idle();

    // Partial byte-enable merge: 0x11223344 with 0xAABBCCDD under be=0101.
    issue(1'b1, 32'h200, 32'h11223344, 4'hF);
    issue(1'b1, 32'h200, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 32'h200, 32'h0, 4'h0);
    issue(1'b1, 32'h204, 32'h12345678, 4'h0);
    issue(1'b0, 32'h204, 32'h0, 4'h0);
    wait_idle();

    // Five reads against a stalled response port.
    rsp_ready = 1'b0;
    fork
      for (int i = 0; i < 5; i++) issue(1'b0, 32'(32'h100 + 4*i), 32'h0, 4'h0);
      begin
        repeat (8) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // Boundary and error cases; errored writes must leave the array alone.
    issue(1'b0, 32'h1FFC, 32'h0, 4'h0);
    issue(1'b0, 32'h2000, 32'h0, 4'h0);
    issue(1'b0, 32'h102,  32'h0, 4'h0);
    issue(1'b1, 32'h2000, 32'hFFFFFFFF, 4'hF);
    issue(1'b1, 32'h102,  32'hFFFFFFFF, 4'hF);
    issue(1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF);
    issue(1'b1, 32'h1FFC, 32'hCAFEF00D, 4'hF);
    issue(1'b0, 32'h1FFC, 32'h0, 4'h0);
    wait_idle();
    peek_all("peek_after_errors");

    // Short write behind a long read stays in order.
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    issue(1'b1, 32'h104, 32'h0BADCAFE, 4'hF);
    issue(1'b0, 32'h104, 32'h0, 4'h0);
    wait_idle();

    // Reset with three requests outstanding.
    rsp_ready = 1'b0;
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    issue(1'b1, 32'h108, 32'h55AA55AA, 4'hF);
    issue(1'b0, 32'h108, 32'h0, 4'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    step();
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    issue(1'b0, 32'h108, 32'h0, 4'h0);
    wait_idle();

    // Randomised traffic with random response back-pressure.
    rsp_rand = 1'b1;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = $urandom_range(0, MEMB - 1);
        1:       ra = 32'(MEMB + 4 * $urandom_range(0, 15));
        2:       ra = $urandom;
        default: ra = 32'(4 * $urandom_range(0, 63));
      endcase
      issue($urandom_range(0, 1) == 1, ra, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) step();
      end
    end
    rsp_rand = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    peek_all("peek_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
